uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (FSM, baud counter and shift
// register in one block) with optional parity and one or two stop bits.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_tx_en       frame request, accepted only while o_tx_ready=1
//   i_tx_data     frame payload, latched on the acceptance edge
//   o_tx_ready    high exactly while the FSM is IDLE
//   o_tx          registered serial line, idle-high
//   o_tx_complete one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_tx_en,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_complete
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Bit counter serves both data bits and stop bits; DATA_BITS >= 5 keeps it wide enough.
    localparam int unsigned BIT_W  = (DATA_BITS > 4) ? $clog2(DATA_BITS) : 2;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam bit                PARITY_EN  = (PARITY_MODE != 0);
    localparam bit                PARITY_ODD = (PARITY_MODE == 1);

    // Elaboration-time parameter legality checks
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q,    state_d;
    logic [BAUD_W-1:0]     baud_q,     baud_d;
    logic [BIT_W-1:0]      bit_q,      bit_d;
    logic [DATA_BITS-1:0]  shift_q,    shift_d;
    logic                  parity_q,   parity_d;
    logic                  tx_q,       tx_d;
    logic                  complete_q, complete_d;
    logic                  bit_end;

    assign bit_end       = (baud_q == BAUD_LAST);
    assign o_tx_ready    = (state_q == IDLE);
    assign o_tx          = tx_q;
    assign o_tx_complete = complete_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            complete_q <= complete_d;
        end
    end

    // Next-state and next-output logic; o_tx is loaded with the value of the
    // bit that begins on the next cycle, so the line stays glitch-free.
    always_comb begin
        state_d    = state_q;
        baud_d     = '0;
        bit_d      = bit_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        complete_d = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_tx_en) begin
                    state_d  = START;
                    shift_d  = i_tx_data;
                    parity_d = (^i_tx_data) ^ PARITY_ODD;
                    tx_d     = 1'b0;
                    bit_d    = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d    = IDLE;
                        bit_d      = '0;
                        complete_d = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: five instances with different frame formats,
// directed frames with hand-computed bit patterns, and a line monitor that
// rebuilds each frame and checks it against a per-instance expectation queue.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int CPB  = 4;
    localparam int NDUT = 5;

    // Instance formats: 0 = 8N1, 1 = 7E1, 2 = 7O1, 3 = 8N2, 4 = 9O1
    function automatic int db_f(input int g);
        case (g)
            1, 2:    return 7;
            4:       return 9;
            default: return 8;
        endcase
    endfunction
    function automatic int pm_f(input int g);
        case (g)
            1:       return 2;
            2, 4:    return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sb_f(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    // Expected frame: line bits in send order (bit 0 = start bit)
    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NDUT-1:0] tx_en;
    logic [8:0]      tx_data [NDUT];
    logic [NDUT-1:0] tx;
    logic [NDUT-1:0] ready;
    logic [NDUT-1:0] complete;

    int checks = 0;
    int errors = 0;

    frame_t      exp_q    [NDUT][$];
    bit          in_frame [NDUT];
    int          k        [NDUT];
    logic [15:0] cap      [NDUT];
    bit          bad      [NDUT];
    logic        prev     [NDUT];
    int          run      [NDUT];
    int          gap      [NDUT];
    int          ncomp    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB = db_f(g);
        uart_tx_frame #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_MODE  (pm_f(g)),
            .STOP_BITS    (sb_f(g))
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_tx_en       (tx_en[g]),
            .i_tx_data     (tx_data[g][DB-1:0]),
            .o_tx_ready    (ready[g]),
            .o_tx          (tx[g]),
            .o_tx_complete (complete[g])
        );
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: captures each frame and scores it on o_tx_complete
    always @(negedge clk) begin
        frame_t      e;
        logic [15:0] mask;
        for (int g = 0; g < NDUT; g++) begin
            if (!rst_n) begin
                in_frame[g] = 1'b0;
                run[g]      = 0;
            end else begin
                if (complete[g]) begin
                    ncomp[g]++;
                    check($sformatf("dut%0d complete matches pending frame", g),
                          longint'(in_frame[g] && exp_q[g].size() != 0), 1);
                    if (in_frame[g] && exp_q[g].size() != 0) begin
                        e    = exp_q[g].pop_front();
                        mask = 16'((32'd1 << e.n) - 32'd1);
                        check($sformatf("dut%0d frame bits", g), longint'(cap[g] & mask), longint'(e.bits));
                        check($sformatf("dut%0d frame cycles", g), k[g], e.n * CPB);
                        check($sformatf("dut%0d frame shape/ready", g), longint'(bad[g]), 0);
                    end
                    in_frame[g] = 1'b0;
                end else begin
                    if (!in_frame[g] && tx[g] == 1'b0) begin
                        in_frame[g] = 1'b1;
                        k[g]        = 0;
                        cap[g]      = '0;
                        bad[g]      = 1'b0;
                        gap[g]      = run[g];
                    end
                    if (in_frame[g]) begin
                        if (ready[g]) bad[g] = 1'b1;
                        if ((k[g] % CPB) != 0 && tx[g] != prev[g]) bad[g] = 1'b1;
                        if ((k[g] % CPB) == CPB / 2 && (k[g] / CPB) < 16) cap[g][k[g] / CPB] = tx[g];
                        k[g]++;
                    end
                end
                run[g] = tx[g] ? run[g] + 1 : 0;
            end
            prev[g] = tx[g];
        end
    end

    task automatic expect_frame(input int g, input logic [15:0] bits, input int n);
        frame_t e;
        e.bits = bits;
        e.n    = n;
        exp_q[g].push_back(e);
    endtask

    task automatic wait_ready(input int g);
        int t = 0;
        while (!ready[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d ready before request", g), longint'(ready[g]), 1);
    endtask

    task automatic send(input int g, input logic [8:0] data);
        wait_ready(g);
        tx_en[g]   = 1'b1;
        tx_data[g] = data;
        @(negedge clk);
        tx_en[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while ((exp_q[g].size() != 0 || !ready[g]) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d expectations drained", g), exp_q[g].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        int t;
        int left;
        rst_n = 1'b0;
        tx_en = '0;
        for (int g = 0; g < NDUT; g++) tx_data[g] = '0;
        for (int g = 0; g < NDUT; g++) begin
            ncomp[g] = 0;
            run[g]   = 0;
            gap[g]   = 0;
        end
        repeat (3) @(negedge clk);
        check("reset o_tx", longint'(tx), 5'h1F);
        check("reset o_tx_ready", longint'(ready), 5'h1F);
        check("reset o_tx_complete", longint'(complete), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5
        expect_frame(0, 16'b1_10100101_0, 10);
        send(0, 9'h0A5);
        wait_idle(0);

        // 7-bit parity frames
        expect_frame(1, 16'b1_0_1010101_0, 10);
        send(1, 9'h055);
        expect_frame(2, 16'b1_1_1010101_0, 10);
        send(2, 9'h055);
        wait_idle(1);
        wait_idle(2);
        expect_frame(2, 16'b1_0_1010100_0, 10);
        send(2, 9'h054);
        wait_idle(2);

        // 8N2 back-to-back with i_tx_en held high
        c0 = ncomp[3];
        wait_ready(3);
        expect_frame(3, 16'b11_00000000_0, 11);
        expect_frame(3, 16'b11_11111111_0, 11);
        tx_en[3]   = 1'b1;
        tx_data[3] = 9'h000;
        @(negedge clk);
        tx_data[3] = 9'h0FF;
        t = 0;
        while (!ready[3] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("dut3 ready in complete cycle", longint'(ready[3] && complete[3]), 1);
        @(negedge clk);
        tx_en[3] = 1'b0;
        wait_idle(3);
        check("dut3 high cycles between frames", gap[3], 9);
        check("dut3 complete pulses", ncomp[3] - c0, 2);

        // Request while busy is ignored
        c0 = ncomp[0];
        expect_frame(0, 16'b1_00111100_0, 10);
        send(0, 9'h03C);
        repeat (9) @(negedge clk);
        check("dut0 busy at ignored request", longint'(ready[0]), 0);
        tx_en[0]   = 1'b1;
        tx_data[0] = 9'h0C3;
        @(negedge clk);
        tx_en[0] = 1'b0;
        wait_idle(0);
        repeat (60) @(negedge clk);
        check("dut0 single complete pulse", ncomp[0] - c0, 1);

        // Reset mid-frame, then a clean frame
        c0 = ncomp[0];
        send(0, 9'h0F0);
        repeat (14) @(negedge clk);
        check("dut0 line low before reset", longint'(tx[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset o_tx", longint'(tx[0]), 1);
        check("async reset o_tx_ready", longint'(ready[0]), 1);
        check("async reset o_tx_complete", longint'(complete[0]), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        expect_frame(0, 16'b1_10000001_0, 10);
        send(0, 9'h081);
        wait_idle(0);
        check("dut0 completes after reset", ncomp[0] - c0, 1);

        // 9O1 all ones
        expect_frame(4, 16'b1_0_111111111_0, 12);
        send(4, 9'h1FF);
        wait_idle(4);

        left = 0;
        for (int g = 0; g < NDUT; g++) left += exp_q[g].size();
        check("all expected frames seen", left, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
